// File: rtl/dual_port_ram_sync.sv
// dual_port_ram_sync
// True dual-port synchronous RAM on one clock. Registered read with valid
// flag, selectable read-during-write behaviour, fixed-priority resolution of
// same-address double writes with a collision pulse, and a zero-fill sweep
// of the whole array after every reset.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_CLEAR | sweeping zeros into mem[0..DEPTH-1]; busy, ports ignored
// S_READY | normal two-port operation; left only through reset
module dual_port_ram_sync #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = 0,
  parameter int PRIO_A   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              vld_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              vld_b,
  output logic              busy,
  output logic              collision
);

  localparam int DEPTH       = 2 ** ADDR_W;
  localparam bit WRITE_FIRST = (RDW_MODE != 0);
  localparam bit A_WINS      = (PRIO_A != 0);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              wr_a;
  logic              wr_b;
  logic              rd_a;
  logic              rd_b;
  logic              same_addr;
  logic              both_wr_same;
  logic              mem_wr_a;
  logic              mem_wr_b;
  logic [DATA_W-1:0] win_din;
  logic              hit_a;
  logic              hit_b;
  logic [DATA_W-1:0] new_a;
  logic [DATA_W-1:0] new_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              coll_nxt;

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  // Next state: leave the sweep once the last address has been zeroed.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_addr == {ADDR_W{1'b1}}) state_nxt = S_READY;
      S_READY: state_nxt = S_READY;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Sweep address counter, runs only while clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   clr_addr <= '0;
    else if (state == S_CLEAR) clr_addr <= clr_addr + 1'b1;
  end

  assign ready = (state == S_READY);
  assign busy  = ~ready;

  // Port qualification, write arbitration and read-data selection.
  always_comb begin
    wr_a         = ready & en_a & we_a;
    wr_b         = ready & en_b & we_b;
    rd_a         = ready & en_a;
    rd_b         = ready & en_b;
    same_addr    = (addr_a == addr_b);
    both_wr_same = wr_a & wr_b & same_addr;
    // On a same-address double write only the winner touches the array.
    mem_wr_a     = wr_a & ~(both_wr_same & ~A_WINS);
    mem_wr_b     = wr_b & ~(both_wr_same &  A_WINS);
    win_din      = A_WINS ? din_a : din_b;
    // Word that will be stored at each port's address this cycle, if any.
    hit_a        = wr_a | (wr_b & same_addr);
    hit_b        = wr_b | (wr_a & same_addr);
    new_a        = both_wr_same ? win_din : (wr_a ? din_a : din_b);
    new_b        = both_wr_same ? win_din : (wr_b ? din_b : din_a);
    rdata_a      = (WRITE_FIRST && hit_a) ? new_a : mem[addr_a];
    rdata_b      = (WRITE_FIRST && hit_b) ? new_b : mem[addr_b];
    coll_nxt     = ready & en_a & en_b & same_addr & (we_a | we_b);
  end

  // Memory array: zero-fill during the sweep, port writes once ready.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_addr] <= '0;
    end else begin
      if (mem_wr_a) mem[addr_a] <= din_a;
      if (mem_wr_b) mem[addr_b] <= din_b;
    end
  end

  // Registered read outputs and collision flag; dout holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_a    <= '0;
      dout_b    <= '0;
      vld_a     <= 1'b0;
      vld_b     <= 1'b0;
      collision <= 1'b0;
    end else begin
      vld_a     <= rd_a;
      vld_b     <= rd_b;
      collision <= coll_nxt;
      if (rd_a) dout_a <= rdata_a;
      if (rd_b) dout_b <= rdata_b;
    end
  end

endmodule

// File: tb/tb_dual_port_ram_sync.sv
// tb_dual_port_ram_sync
// Random and directed stimulus against an array-based reference model;
// expected responses are queued by the driver and consumed by a monitor.
module tb_dual_port_ram_sync;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int RDW   = 0;
  localparam int PRIO  = 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] din_a = '0, din_b = '0;
  logic [DW-1:0] dout_a, dout_b;
  logic          vld_a, vld_b, busy, collision;

  dual_port_ram_sync #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(RDW), .PRIO_A(PRIO)) dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a), .vld_a(vld_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b), .vld_b(vld_b),
    .busy(busy), .collision(collision)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [1:0]    qs[$];          // {collision, busy}
  logic [DW-1:0] ref_mem [DEPTH];
  int            clear_left = 0;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus (at a negedge) and queue what it should produce.
  // xa/xb >= 0 force a fixed expected read value for directed checks.
  task automatic drive(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                       input int xa = -1, input int xb = -1);
    logic [DW-1:0] old_mem [DEPTH];
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    if (clear_left > 0) begin
      qs.push_back({1'b0, (clear_left > 1)});
      clear_left--;
    end else begin
      old_mem = ref_mem;
      if (ea && wa) ref_mem[aa] = da;
      if (eb && wb && !(ea && wa && aa == ab && PRIO != 0)) ref_mem[ab] = db;
      if (ea) qa.push_back(xa >= 0 ? DW'(xa) : ((RDW != 0) ? ref_mem[aa] : old_mem[aa]));
      if (eb) qb.push_back(xb >= 0 ? DW'(xb) : ((RDW != 0) ? ref_mem[ab] : old_mem[ab]));
      qs.push_back({(ea && eb && aa == ab && (wa || wb)), 1'b0});
    end
  endtask

  task automatic step(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input int xa = -1, input int xb = -1);
    @(negedge clk);
    drive(ea, wa, aa, da, eb, wb, ab, db, xa, xb);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_step(input bit narrow);
    logic [AW-1:0] aa, ab;
    aa = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
    ab = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
    step(1'($urandom), 1'($urandom), aa, DW'($urandom),
         1'($urandom), 1'($urandom), ab, DW'($urandom));
  endtask

  // Assert reset, check the asynchronous effect, then run the sweep with
  // random (to-be-ignored) port activity.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst dout_a", dout_a, 0);
    check("rst dout_b", dout_b, 0);
    check("rst vld", {vld_a, vld_b}, 0);
    check("rst collision", collision, 0);
    check("rst busy", busy, 1);
    qa.delete(); qb.delete(); qs.delete();
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    clear_left = DEPTH;
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    repeat (DEPTH - 1) rand_step(1'b0);
  endtask

  // Monitor: one sample per cycle, #1 after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (vld_a) begin
          if (qa.size() == 0) check("vld_a unexpected", 1, 0);
          else check("dout_a", dout_a, qa.pop_front());
        end
        if (vld_b) begin
          if (qb.size() == 0) check("vld_b unexpected", 1, 0);
          else check("dout_b", dout_b, qb.pop_front());
        end
        if (qa.size() != 0) begin check("vld_a missing", 0, 1); qa.delete(); end
        if (qb.size() != 0) begin check("vld_b missing", 0, 1); qb.delete(); end
        if (qs.size() != 0) begin
          logic [1:0] s;
          s = qs.pop_front();
          check("collision", collision, s[1]);
          check("busy", busy, s[0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // every address reads zero after the sweep
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(DEPTH - 1 - i), '0, 0, 0);

    // write on A, read back on B next cycle
    step(1'b1, 1'b1, 4'd2, 8'hAA, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd2, '0, -1, 'hAA);

    // independent writes, then reads
    step(1'b1, 1'b1, 4'd4, 8'h55, 1'b1, 1'b1, 4'd6, 8'h66);
    step(1'b1, 1'b0, 4'd4, '0, 1'b1, 1'b0, 4'd6, '0, 'h55, 'h66);

    // same-address double write
    step(1'b1, 1'b1, 4'd8, 8'hF0, 1'b1, 1'b1, 4'd8, 8'h0F);
    step(1'b1, 1'b0, 4'd8, '0, 1'b0, 1'b0, '0, '0, (PRIO != 0) ? 'hF0 : 'h0F);

    // cross-port read during write
    step(1'b1, 1'b1, 4'd3, 8'h11, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 4'd3, 8'h22, 1'b1, 1'b0, 4'd3, '0, -1, (RDW != 0) ? 'h22 : 'h11);
    idle();

    for (int i = 0; i < 600; i++) rand_step(i % 2 == 0);

    // reset in the middle of a write burst
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, AW'($urandom), DW'($urandom), 1'b1, 1'b1, AW'($urandom), DW'($urandom));
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i), '0, 0, 0);

    for (int i = 0; i < 200; i++) rand_step(1'b1);
    idle();
    idle();
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
